// File: rtl/fetch_stage_if.sv
// Bundle of fetch-stage signals: hazard/EX controls, instruction-memory port and IF/ID outputs.
// The slave modport is the fetch stage itself; master is its environment.
interface fetch_stage_if #(
    parameter int PC_W = 32
);
    logic            stall;
    logic            redirect_valid;
    logic [PC_W-1:0] redirect_pc;
    logic [PC_W-1:0] imem_addr;
    logic [31:0]     imem_rdata;
    logic [PC_W-1:0] ifid_pc;
    logic [31:0]     ifid_instr;
    logic            ifid_valid;
    logic            halted;
    logic [31:0]     fetch_count;

    modport master (
        output stall, redirect_valid, redirect_pc, imem_rdata,
        input  imem_addr, ifid_pc, ifid_instr, ifid_valid, halted, fetch_count
    );

    modport slave (
        input  stall, redirect_valid, redirect_pc, imem_rdata,
        output imem_addr, ifid_pc, ifid_instr, ifid_valid, halted, fetch_count
    );
endinterface

// File: rtl/fetch_stage.sv
// RV32 instruction-fetch stage: PC register, IF/ID pipeline register, redirect/flush,
// hazard stall and halt-on-ecall, with a saturating count of fetched instructions.
module fetch_stage #(
    parameter int              PC_W       = 32,
    parameter logic [PC_W-1:0] RESET_PC   = '0,
    parameter logic [31:0]     NOP_INSTR  = 32'h0000_0013,
    parameter logic [31:0]     HALT_INSTR = 32'h0000_0073
) (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.slave  bus
);
    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    localparam logic [PC_W-1:0] ALIGN_MASK = {{(PC_W-2){1'b1}}, 2'b00};
    localparam logic [PC_W-1:0] PC_STEP    = PC_W'(4);

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] ifid_pc_q, ifid_pc_d;
    logic [31:0]     ifid_instr_q, ifid_instr_d;
    logic            ifid_valid_q, ifid_valid_d;
    logic [31:0]     fetch_count_q, fetch_count_d;
    logic            halted_q, halted_d;
    logic [31:0]     count_inc;

    assign count_inc = (fetch_count_q == 32'hFFFF_FFFF) ? fetch_count_q : fetch_count_q + 32'd1;

    // Priority: redirect beats stall, stall beats halt detect and normal advance.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        ifid_pc_d     = ifid_pc_q;
        ifid_instr_d  = ifid_instr_q;
        ifid_valid_d  = ifid_valid_q;
        fetch_count_d = fetch_count_q;
        if (bus.redirect_valid) begin
            pc_d         = bus.redirect_pc & ALIGN_MASK;
            ifid_pc_d    = pc_q;
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
            state_d      = RUN;
        end else if (!bus.stall) begin
            case (state_q)
                RUN: begin
                    ifid_pc_d     = pc_q;
                    ifid_instr_d  = bus.imem_rdata;
                    ifid_valid_d  = 1'b1;
                    fetch_count_d = count_inc;
                    if (bus.imem_rdata == HALT_INSTR) begin
                        state_d = HALT;
                    end else begin
                        pc_d = pc_q + PC_STEP;
                    end
                end
                HALT: begin
                    ifid_pc_d    = pc_q;
                    ifid_instr_d = NOP_INSTR;
                    ifid_valid_d = 1'b0;
                end
                default: state_d = RUN;
            endcase
        end
        halted_d = (state_d == HALT);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= RUN;
            pc_q          <= RESET_PC;
            ifid_pc_q     <= '0;
            ifid_instr_q  <= NOP_INSTR;
            ifid_valid_q  <= 1'b0;
            fetch_count_q <= '0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            ifid_pc_q     <= ifid_pc_d;
            ifid_instr_q  <= ifid_instr_d;
            ifid_valid_q  <= ifid_valid_d;
            fetch_count_q <= fetch_count_d;
            halted_q      <= halted_d;
        end
    end

    assign bus.imem_addr   = pc_q;
    assign bus.ifid_pc     = ifid_pc_q;
    assign bus.ifid_instr  = ifid_instr_q;
    assign bus.ifid_valid  = ifid_valid_q;
    assign bus.halted      = halted_q;
    assign bus.fetch_count = fetch_count_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage with a behavioural instruction memory
// returning 0x93+addr, except 0x73 (halt) at address 0x10.
module tb_fetch_stage;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    fetch_stage_if #(.PC_W(32)) bus_if ();

    fetch_stage #(
        .PC_W      (32),
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0013),
        .HALT_INSTR(32'h0000_0073)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_if)
    );

    assign bus_if.imem_rdata = (bus_if.imem_addr == 32'h10) ? 32'h73 : bus_if.imem_addr + 32'h93;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        stall;
        logic        rv;
        logic [31:0] rpc;
        logic [31:0] addr;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        vld;
        logic        hlt;
        logic [31:0] cnt;
    } vec_t;

    vec_t tbl [19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic s, input logic v, input logic [31:0] p);
        reset                 = r;
        bus_if.stall          = s;
        bus_if.redirect_valid = v;
        bus_if.redirect_pc    = p;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [31:0] addr, input logic [31:0] pc,
                           input logic [31:0] instr, input logic vld, input logic hlt,
                           input logic [31:0] cnt);
        chk({tag, ".imem_addr"},   bus_if.imem_addr, addr);
        chk({tag, ".ifid_pc"},     bus_if.ifid_pc, pc);
        chk({tag, ".ifid_instr"},  bus_if.ifid_instr, instr);
        chk({tag, ".ifid_valid"},  32'(bus_if.ifid_valid), 32'(vld));
        chk({tag, ".halted"},      32'(bus_if.halted), 32'(hlt));
        chk({tag, ".fetch_count"}, bus_if.fetch_count, cnt);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        //           rst  stl  rv   rpc            addr           ifid_pc        instr          vld  hlt  cnt
        tbl[0]  = '{1'b0,1'b0,1'b0,32'h0,         32'h0,         32'h0,         32'h13,        1'b0,1'b0,32'd0};
        tbl[1]  = '{1'b0,1'b0,1'b0,32'h0,         32'h0,         32'h0,         32'h13,        1'b0,1'b0,32'd0};
        tbl[2]  = '{1'b1,1'b0,1'b0,32'h0,         32'h4,         32'h0,         32'h93,        1'b1,1'b0,32'd1};
        tbl[3]  = '{1'b1,1'b0,1'b0,32'h0,         32'h8,         32'h4,         32'h97,        1'b1,1'b0,32'd2};
        tbl[4]  = '{1'b1,1'b1,1'b0,32'h0,         32'h8,         32'h4,         32'h97,        1'b1,1'b0,32'd2};
        tbl[5]  = '{1'b1,1'b1,1'b0,32'h0,         32'h8,         32'h4,         32'h97,        1'b1,1'b0,32'd2};
        tbl[6]  = '{1'b1,1'b0,1'b0,32'h0,         32'hC,         32'h8,         32'h9B,        1'b1,1'b0,32'd3};
        tbl[7]  = '{1'b1,1'b0,1'b0,32'h0,         32'h10,        32'hC,         32'h9F,        1'b1,1'b0,32'd4};
        tbl[8]  = '{1'b1,1'b0,1'b0,32'h0,         32'h10,        32'h10,        32'h73,        1'b1,1'b1,32'd5};
        tbl[9]  = '{1'b1,1'b0,1'b0,32'h0,         32'h10,        32'h10,        32'h13,        1'b0,1'b1,32'd5};
        tbl[10] = '{1'b1,1'b0,1'b1,32'h40,        32'h40,        32'h10,        32'h13,        1'b0,1'b0,32'd5};
        tbl[11] = '{1'b1,1'b0,1'b0,32'h0,         32'h44,        32'h40,        32'hD3,        1'b1,1'b0,32'd6};
        tbl[12] = '{1'b1,1'b1,1'b1,32'h103,       32'h100,       32'h44,        32'h13,        1'b0,1'b0,32'd6};
        tbl[13] = '{1'b1,1'b0,1'b0,32'h0,         32'h104,       32'h100,       32'h193,       1'b1,1'b0,32'd7};
        tbl[14] = '{1'b1,1'b0,1'b1,32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h104,       32'h13,        1'b0,1'b0,32'd7};
        tbl[15] = '{1'b1,1'b0,1'b0,32'h0,         32'h0,         32'hFFFF_FFFC, 32'h8F,        1'b1,1'b0,32'd8};
        tbl[16] = '{1'b1,1'b0,1'b0,32'h0,         32'h4,         32'h0,         32'h93,        1'b1,1'b0,32'd9};
        tbl[17] = '{1'b1,1'b1,1'b0,32'h0,         32'h4,         32'h0,         32'h93,        1'b1,1'b0,32'd9};
        tbl[18] = '{1'b0,1'b1,1'b0,32'h0,         32'h0,         32'h0,         32'h13,        1'b0,1'b0,32'd0};

        reset                 = 1'b0;
        bus_if.stall          = 1'b0;
        bus_if.redirect_valid = 1'b0;
        bus_if.redirect_pc    = '0;
        #1;

        for (int i = 0; i < 19; i++) begin
            step(tbl[i].rst_n, tbl[i].stall, tbl[i].rv, tbl[i].rpc);
            chk_all($sformatf("vec%0d", i), tbl[i].addr, tbl[i].pc, tbl[i].instr,
                    tbl[i].vld, tbl[i].hlt, tbl[i].cnt);
        end

        // Run back into the halt at 0x10, stall while halted, then reset while redirecting.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("seq.advance.imem_addr", bus_if.imem_addr, 32'h10);
        chk("seq.advance.fetch_count", bus_if.fetch_count, 32'd4);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        chk_all("seq.halt", 32'h10, 32'h10, 32'h73, 1'b1, 1'b1, 32'd5);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk_all("seq.halt_stall", 32'h10, 32'h10, 32'h73, 1'b1, 1'b1, 32'd5);
        step(1'b0, 1'b1, 1'b1, 32'h200);
        chk_all("seq.reset_in_halt", 32'h0, 32'h0, 32'h13, 1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        chk_all("seq.restart", 32'h4, 32'h0, 32'h93, 1'b1, 1'b0, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage RV32 pipeline, directly upstream of decode.
- Owns the PC register, drives the instruction-memory address, and produces the IF/ID pipeline register (ifid_pc, ifid_instr, ifid_valid) that decode consumes.
- Supports stall from the hazard unit, branch/jump redirect from EX with flush, and halt on a halt instruction.

Parameters:
PC_W, 32, width of PC and address bus
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0)
HALT_INSTR, 32'h0000_0073, instruction encoding that halts fetch (ecall)

Ports:
clk  input  1  system clock; all state updates on posedge
reset  input  1  synchronous, active-low reset; sampled only on posedge clk
stall  input  1  hold PC and IF/ID (hazard unit)
redirect_valid  input  1  EX requests control-flow change
redirect_pc  input  PC_W  redirect target
imem_addr  output  PC_W  instruction memory address = current PC (combinational)
imem_rdata  input  32  instruction word; combinational read, valid in same cycle
ifid_pc  output  PC_W  PC of instruction in IF/ID
ifid_instr  output  32  instruction in IF/ID
ifid_valid  output  1  IF/ID holds a real instruction
halted  output  1  fetch halted
fetch_count  output  32  instructions fetched into IF/ID, saturating

Behaviour:
- States: RUN, HALT. Registers: pc, ifid_pc, ifid_instr, ifid_valid, fetch_count, state.
- Reset (reset==0 at posedge) overrides all other inputs, including mid-stall, mid-redirect and in HALT:
  - pc=RESET_PC, ifid_pc=0, ifid_instr=NOP_INSTR, ifid_valid=0, fetch_count=0, state=RUN, halted=0.
- imem_addr = pc at all times. An instruction at pc appears on ifid_* after the next posedge (one-cycle latency).
- Priority per edge: reset > redirect_valid > stall > halt detect > normal advance.
- Redirect (any state, stall ignored):
  - pc <= {redirect_pc[PC_W-1:2], 2'b00} (low bits forced to 0).
  - ifid_valid <= 0, ifid_instr <= NOP_INSTR, ifid_pc <= current pc (flush).
  - fetch_count holds; state <= RUN (clears halted).
- Stall (no redirect): pc, ifid_*, fetch_count and state all hold.
- RUN, no stall/redirect, imem_rdata != HALT_INSTR:
  - ifid_pc <= pc, ifid_instr <= imem_rdata, ifid_valid <= 1.
  - pc <= pc + 4, modulo 2^PC_W, so 0xFFFF_FFFC wraps to 0.
  - fetch_count <= fetch_count + 1, saturating at 0xFFFF_FFFF.
- RUN, no stall/redirect, imem_rdata == HALT_INSTR:
  - Halt instruction is latched into IF/ID like any other (valid=1, count+1).
  - pc holds; state <= HALT.
- HALT, no stall/redirect: pc holds; ifid_valid <= 0, ifid_instr <= NOP_INSTR, ifid_pc <= pc; count holds.
- halted = (state==HALT), registered.
- Misaligned pc is impossible by construction; imem_rdata is never checked for X.

Test Plan:
- Reset held 2 cycles, imem returns 0x0000_0093+addr, then released → cycle 1 after release: ifid_pc=0, ifid_valid=1, ifid_instr=0x93; after 3 advancing cycles: imem_addr=0xC, fetch_count=3.
- Stall asserted 2 cycles while imem_addr=0x8 → ifid_pc stays 0x4, imem_addr stays 0x8, fetch_count unchanged; first cycle after release: ifid_pc=0x8.
- redirect_valid=1, redirect_pc=0x103, stall=1 in the same cycle → next cycle: imem_addr=0x100, ifid_valid=0, ifid_instr=0x13, count unchanged; following cycle: ifid_pc=0x100, ifid_valid=1.
- imem returns 0x73 at 0x10 → next cycle: ifid_instr=0x73, ifid_valid=1, halted=1, imem_addr=0x10; cycle after: ifid_valid=0. Then redirect to 0x40 → halted=0, imem_addr=0x40.
- Redirect to 0xFFFF_FFFC, one advance → ifid_pc=0xFFFF_FFFC, imem_addr=0x0.
- reset=0 asserted during active stall with fetch_count=5 → after that edge: all outputs at reset values, imem_addr=RESET_PC, halted=0.
